// File: rtl/btn_pkg.sv
// btn_pkg: shared constants and types for the button event generator
package btn_pkg;
  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;
  localparam int EVT_W = 4;
  localparam int DEF_REPEAT_DELAY = 50_000_000;
  localparam int DEF_REPEAT_PERIOD = 15_000_000;
  localparam int DEF_FIFO_DEPTH = 4;
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} btn_state_t;
endpackage

// File: rtl/btn_event_gen_fifo.sv
// event_fifo: synchronous FIFO with full/empty flags and a zeroed head when empty
module event_fifo #(
  parameter int W = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_wr, do_rd;
  assign full = cnt == DEPTH[AW:0];
  assign empty = cnt == '0;
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);
  assign rdata = empty ? '0 : mem[rp];
  always_ff @(posedge clk) begin
    if (do_wr) mem[wp] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= do_wr ? wp + AW'(1) : wp;
      rp <= do_rd ? rp + AW'(1) : rp;
      cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end
endmodule

// File: rtl/btn_event_gen.sv
// btn_event_gen: turns debounced button levels into queued press/repeat events
module btn_event_gen import btn_pkg::*; #(
  parameter int N_BTN = 5,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] calm,
  output logic             event_valid,
  input  logic             event_ready,
  output logic [2:0]       event_btn,
  output logic             event_rep,
  output logic             overflow
);
  localparam int CNT_MAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW = CNT_MAX > 2 ? $clog2(CNT_MAX) : 1;
  logic [N_BTN-1:0] prev, ev, ev_rep, pending, pending_rep, grant, accept;
  logic [2:0] idx;
  logic push, full, empty;
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_state_t st, st_n;
    logic [CW-1:0] cnt, cnt_n;
    logic hit;
    assign hit = st == S_HOLD ? cnt == CW'(REPEAT_DELAY - 1) : cnt == CW'(REPEAT_PERIOD - 1);
    always_ff @(posedge clk) begin
      if (rst) begin
        st <= S_IDLE;
        cnt <= '0;
      end else begin
        st <= st_n;
        cnt <= cnt_n;
      end
    end
    always_comb begin
      st_n = !calm[i] ? S_IDLE : st == S_IDLE ? (prev[i] ? S_IDLE : S_HOLD) : st == S_HOLD && hit ? S_REPEAT : st;
      cnt_n = st == S_IDLE || !calm[i] || hit ? '0 : cnt + CW'(1);
    end
    assign ev[i] = calm[i] && (st == S_IDLE ? !prev[i] : hit);
    assign ev_rep[i] = st != S_IDLE;
  end
  always_comb begin
    idx = '0;
    for (int j = N_BTN - 1; j >= 0; j--) idx = pending[j] ? 3'(j) : idx;
  end
  assign push = |pending && (!full || (event_ready && !empty));
  assign grant = push ? N_BTN'(1) << idx : '0;
  assign accept = ev & ~pending;
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= '1;
      pending <= '0;
      pending_rep <= '0;
      overflow <= 1'b0;
    end else begin
      prev <= calm;
      pending <= (pending & ~grant) | accept;
      pending_rep <= (pending_rep & ~accept) | (ev_rep & accept);
      overflow <= overflow | |(ev & pending);
    end
  end
  event_fifo #(.W(EVT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr(push),
    .wdata({pending_rep[idx], idx}),
    .rd(event_ready),
    .rdata({event_rep, event_btn}),
    .full(full),
    .empty(empty)
  );
  assign event_valid = !empty;
endmodule
